// File: rtl/alu_md.sv
// -----------------------------------------------------------------------------
// alu_md - execute-stage ALU with iterative multiply/divide and HI/LO registers
//
// Single-cycle operations (shifts, add/sub, logic, LUI, set-less-than, MFHI/MFLO)
// produce alu_res combinationally in the EX cycle. MULT/MULTU/DIV/DIVU run over
// WIDTH+2 cycles through an IDLE -> RUN -> FIX state machine that owns HI/LO.
// While it runs, any HI/LO-class instruction in EX is held through stall.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   data1     in   operand A (rs)
//   data2     in   operand B (rt / immediate)
//   shamt     in   shift amount
//   alu_ctrl  in   5-bit operation select
//   valid_in  in   EX holds a live instruction
//   flush     in   abort an in-flight multiply/divide
//   alu_res   out  combinational result
//   zero      out  combinational, data1 == data2
//   overflow  out  combinational signed overflow for ADD/SUB
//   stall     out  combinational, hold the EX instruction
//   busy      out  registered, multiply/divide in progress
//   md_done   out  registered one-cycle completion pulse
//   hi, lo    out  registered architectural HI/LO
// -----------------------------------------------------------------------------
module alu_md #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [4:0]         alu_ctrl,
    input  logic               valid_in,
    input  logic               flush,
    output logic [WIDTH-1:0]   alu_res,
    output logic               zero,
    output logic               overflow,
    output logic               stall,
    output logic               busy,
    output logic               md_done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    localparam logic [4:0] OP_SLL   = 5'h00;
    localparam logic [4:0] OP_ADD   = 5'h01;
    localparam logic [4:0] OP_SUB   = 5'h02;
    localparam logic [4:0] OP_NOR   = 5'h03;
    localparam logic [4:0] OP_AND   = 5'h04;
    localparam logic [4:0] OP_OR    = 5'h05;
    localparam logic [4:0] OP_XOR   = 5'h06;
    localparam logic [4:0] OP_LUI   = 5'h07;
    localparam logic [4:0] OP_SRA   = 5'h08;
    localparam logic [4:0] OP_SLT   = 5'h0A;
    localparam logic [4:0] OP_SLTU  = 5'h0B;
    localparam logic [4:0] OP_CMP   = 5'h0E;
    localparam logic [4:0] OP_SRL   = 5'h0F;
    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_MFHI  = 5'h14;
    localparam logic [4:0] OP_MFLO  = 5'h15;
    localparam logic [4:0] OP_MTHI  = 5'h16;
    localparam logic [4:0] OP_MTLO  = 5'h17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Magnitude of an operand; unsigned operations pass the value through.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             signed_op);
        if (signed_op && v[WIDTH-1]) begin
            magnitude = ~v + ONE_W;
        end else begin
            magnitude = v;
        end
    endfunction

    state_t               state_r;
    logic [CNT_W-1:0]     count_r;
    logic [2*WIDTH-1:0]   acc_r;     // product, or {remainder, quotient/dividend}
    logic [WIDTH-1:0]     opnd_r;    // multiplicand or divisor magnitude
    logic                 is_div_r;
    logic                 neg_q_r;   // negate product/quotient at the end
    logic                 neg_rem_r; // remainder follows the dividend sign
    logic                 div0_r;
    logic                 busy_r;
    logic                 md_done_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic [WIDTH-1:0]     sum_s;
    logic [WIDTH-1:0]     diff_s;
    logic [WIDTH-1:0]     alu_res_s;
    logic                 overflow_s;
    logic                 slt_s;
    logic                 sltu_s;
    logic                 accept_s;
    logic                 md_op_s;
    logic                 signed_op_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH:0]       div_trial_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;

    assign sum_s  = data1 + data2;
    assign diff_s = data1 - data2;
    assign slt_s  = $signed(data1) < $signed(data2);
    assign sltu_s = data1 < data2;

    // Codes 10..13 are the multi-cycle ops; 10..17 all touch HI/LO.
    assign md_op_s     = (alu_ctrl[4:2] == 3'b100);
    assign signed_op_s = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);
    assign accept_s    = valid_in && !flush && !busy_r;

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (acc_r[0]) is set, keeping the carry.
    assign mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                     + {1'b0, (acc_r[0] ? opnd_r : {WIDTH{1'b0}})};

    // One restoring-divide step: shift the next dividend bit into the partial
    // remainder and try subtracting the divisor; bit WIDTH flags a borrow.
    assign div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    assign div_trial_s = div_shift_s - {1'b0, opnd_r};

    assign prod_fix_s = neg_q_r   ? (~acc_r + ONE_2W) : acc_r;
    assign quo_fix_s  = neg_q_r   ? (~acc_r[WIDTH-1:0] + ONE_W) : acc_r[WIDTH-1:0];
    assign rem_fix_s  = neg_rem_r ? (~acc_r[2*WIDTH-1:WIDTH] + ONE_W)
                                  : acc_r[2*WIDTH-1:WIDTH];

    // Single-cycle result mux
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (alu_ctrl)
            OP_SLL:  alu_res_s = data1 << shamt;
            OP_SRL:  alu_res_s = data1 >> shamt;
            OP_SRA:  alu_res_s = $signed(data1) >>> shamt;
            OP_ADD:  alu_res_s = sum_s;
            OP_SUB:  alu_res_s = diff_s;
            OP_AND:  alu_res_s = data1 & data2;
            OP_OR:   alu_res_s = data1 | data2;
            OP_XOR:  alu_res_s = data1 ^ data2;
            OP_NOR:  alu_res_s = ~(data1 | data2);
            OP_LUI:  alu_res_s = {data2[HALF-1:0], {HALF{1'b0}}};
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, sltu_s};
            OP_CMP:  alu_res_s = {WIDTH{1'b0}};
            OP_MFHI: alu_res_s = hi_r;
            OP_MFLO: alu_res_s = lo_r;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Signed overflow: operands (B inverted for SUB) agree in sign, result differs
    always_comb begin
        overflow_s = 1'b0;
        if (alu_ctrl == OP_ADD) begin
            overflow_s = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                         (sum_s[WIDTH-1] != data1[WIDTH-1]);
        end else if (alu_ctrl == OP_SUB) begin
            overflow_s = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                         (diff_s[WIDTH-1] != data1[WIDTH-1]);
        end else begin
            overflow_s = 1'b0;
        end
    end

    // Sequencer, multiply/divide datapath and HI/LO architectural state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            count_r   <= {CNT_W{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            div0_r    <= 1'b0;
            busy_r    <= 1'b0;
            md_done_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            md_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && md_op_s) begin
                        acc_r     <= {{WIDTH{1'b0}}, magnitude(data1, signed_op_s)};
                        opnd_r    <= magnitude(data2, signed_op_s);
                        is_div_r  <= alu_ctrl[1];
                        neg_q_r   <= signed_op_s && (data1[WIDTH-1] ^ data2[WIDTH-1]);
                        neg_rem_r <= signed_op_s && data1[WIDTH-1];
                        div0_r    <= (data2 == {WIDTH{1'b0}});
                        count_r   <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= ST_RUN;
                    end else if (accept_s && (alu_ctrl == OP_MTHI)) begin
                        hi_r <= data1;
                    end else if (accept_s && (alu_ctrl == OP_MTLO)) begin
                        lo_r <= data1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        if (is_div_r) begin
                            if (div_trial_s[WIDTH]) begin
                                acc_r <= {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
                            end else begin
                                acc_r <= {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
                            end
                        end else begin
                            acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
                        end
                        if (count_r == CNT_W'(WIDTH - 1)) begin
                            state_r <= ST_FIX;
                        end else begin
                            state_r <= ST_RUN;
                        end
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        if (is_div_r) begin
                            // Divide by zero: quotient saturates, remainder
                            // (dividend magnitude with dividend sign) is data1.
                            lo_r <= div0_r ? {WIDTH{1'b1}} : quo_fix_s;
                            hi_r <= rem_fix_s;
                        end else begin
                            {hi_r, lo_r} <= prod_fix_s;
                        end
                        md_done_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_res  = alu_res_s;
    assign zero     = (data1 == data2);
    assign overflow = overflow_s;
    assign stall    = valid_in && busy_r && (alu_ctrl[4:3] == 2'b10);
    assign busy     = busy_r;
    assign md_done  = md_done_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_alu_md.sv
// -----------------------------------------------------------------------------
// tb_alu_md - self-checking bench for alu_md (WIDTH = 32)
//
// Inputs are driven on the falling edge; registered outputs are sampled on the
// falling edge, combinational outputs 1 ns later. Cycle k of a multiply/divide
// is the k-th falling edge after the one where it was presented.
// Expected values come from 64-bit integer arithmetic in ref_alu / ref_md.
// -----------------------------------------------------------------------------
module tb_alu_md;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic [4:0]   shamt;
    logic [4:0]   alu_ctrl;
    logic         valid_in;
    logic         flush;
    logic [W-1:0] alu_res;
    logic         zero;
    logic         overflow;
    logic         stall;
    logic         busy;
    logic         md_done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] hi_m = 32'h0;
    logic [W-1:0] lo_m = 32'h0;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
        logic [W-1:0] res;
        logic         ovf;
        logic         zr;
    } sc_vec_t;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] h;
        logic [W-1:0] l;
    } md_vec_t;

    alu_md #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .data1(data1), .data2(data2), .shamt(shamt),
        .alu_ctrl(alu_ctrl), .valid_in(valid_in), .flush(flush),
        .alu_res(alu_res), .zero(zero), .overflow(overflow), .stall(stall),
        .busy(busy), .md_done(md_done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference for single-cycle ops: returns {overflow, result}
    function automatic logic [W:0] ref_alu(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [4:0] sh,
                                           input logic [W-1:0] h, input logic [W-1:0] l);
        longint sa, sb, t;
        logic [63:0] tv;
        logic [W-1:0] r;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'h0;
        ov = 1'b0;
        case (op)
            5'h00: r = a << sh;
            5'h0F: r = a >> sh;
            5'h08: begin tv = sa >>> sh; r = tv[31:0]; end
            5'h01: begin t = sa + sb; tv = t; r = tv[31:0];
                         ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            5'h02: begin t = sa - sb; tv = t; r = tv[31:0];
                         ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            5'h04: r = a & b;
            5'h05: r = a | b;
            5'h06: r = a ^ b;
            5'h03: r = ~(a | b);
            5'h07: r = b << 16;
            5'h0A: r = (sa < sb) ? 32'd1 : 32'd0;
            5'h0B: r = (a < b) ? 32'd1 : 32'd0;
            5'h14: r = h;
            5'h15: r = l;
            default: r = 32'h0;
        endcase
        return {ov, r};
    endfunction

    // Reference for multiply/divide: returns {hi, lo}
    function automatic logic [63:0] ref_md(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, tv, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            5'h10: tv = sa * sb;
            5'h11: tv = ua * ub;
            5'h12: begin
                if (b == 32'h0) tv = {a, 32'hFFFFFFFF};
                else begin qv = sa / sb; rv = sa % sb; tv = {rv[31:0], qv[31:0]}; end
            end
            5'h13: begin
                if (b == 32'h0) tv = {a, 32'hFFFFFFFF};
                else begin qv = ua / ub; rv = ua % ub; tv = {rv[31:0], qv[31:0]}; end
            end
            default: tv = 64'h0;
        endcase
        return tv;
    endfunction

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            5: return W'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0;
        data1 = 32'h0; data2 = 32'h0; shamt = 5'd0; alu_ctrl = 5'h00;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", md_done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
        rst_n = 1'b1;
        hi_m = 32'h0; lo_m = 32'h0;
    endtask

    task automatic test_single_cycle();
        sc_vec_t q[$];
        logic [4:0] ops [0:25] = '{5'h00, 5'h0F, 5'h08, 5'h01, 5'h02, 5'h04, 5'h05,
                                   5'h06, 5'h03, 5'h07, 5'h0A, 5'h0B, 5'h0E, 5'h09,
                                   5'h0C, 5'h0D, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14,
                                   5'h15, 5'h16, 5'h17, 5'h18, 5'h1F};
        logic [W:0] m;
        sc_vec_t v;
        q.push_back('{5'h01, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b1, 1'b0});
        q.push_back('{5'h02, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b1, 1'b0});
        q.push_back('{5'h08, 32'h80000000, 32'h00000000, 5'd4, 32'hF8000000, 1'b0, 1'b0});
        q.push_back('{5'h0B, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000001, 1'b0, 1'b0});
        q.push_back('{5'h0A, 32'h12345678, 32'h12345678, 5'd0, 32'h00000000, 1'b0, 1'b1});
        q.push_back('{5'h0E, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 1'b0, 1'b1});
        q.push_back('{5'h07, 32'h0, 32'h1234ABCD, 5'd0, 32'hABCD0000, 1'b0, 1'b0});
        q.push_back('{5'h03, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1});
        q.push_back('{5'h09, 32'h5, 32'h3, 5'd0, 32'h0, 1'b0, 1'b0});
        for (int i = 0; i < 250; i++) begin
            v.op = ops[$urandom_range(0, 25)];
            v.a  = pick_val();
            v.b  = (i % 9 == 0) ? v.a : pick_val();
            v.sh = 5'($urandom_range(0, 31));
            m    = ref_alu(v.op, v.a, v.b, v.sh, hi_m, lo_m);
            v.res = m[W-1:0];
            v.ovf = m[W];
            v.zr  = (v.a == v.b);
            q.push_back(v);
        end
        valid_in = 1'b0;
        foreach (q[i]) begin
            @(negedge clk);
            alu_ctrl = q[i].op; data1 = q[i].a; data2 = q[i].b; shamt = q[i].sh;
            #1;
            checks++;
            if (alu_res !== q[i].res) begin errors++;
                $display("FAIL sc_res op=%h a=%h b=%h sh=%0d got %h exp %h",
                         q[i].op, q[i].a, q[i].b, q[i].sh, alu_res, q[i].res); end
            checks++;
            if (overflow !== q[i].ovf) begin errors++;
                $display("FAIL sc_ovf op=%h a=%h b=%h got %b exp %b",
                         q[i].op, q[i].a, q[i].b, overflow, q[i].ovf); end
            checks++;
            if (zero !== q[i].zr) begin errors++;
                $display("FAIL sc_zero a=%h b=%h got %b exp %b", q[i].a, q[i].b, zero, q[i].zr); end
        end
    endtask

    task automatic test_muldiv();
        md_vec_t q[$];
        md_vec_t v;
        logic [63:0] m;
        q.push_back('{5'h10, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB});
        q.push_back('{5'h11, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE});
        q.push_back('{5'h13, 32'd100, 32'd7, 32'd2, 32'd14});
        q.push_back('{5'h12, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD});
        q.push_back('{5'h12, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000});
        q.push_back('{5'h12, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF});
        q.push_back('{5'h12, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF});
        q.push_back('{5'h13, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF});
        for (int i = 0; i < 12; i++) begin
            v.op = 5'(16 + $urandom_range(0, 3));
            v.a  = pick_val();
            v.b  = pick_val();
            m    = ref_md(v.op, v.a, v.b);
            v.h  = m[63:32];
            v.l  = m[31:0];
            q.push_back(v);
        end
        foreach (q[i]) begin
            @(negedge clk);
            alu_ctrl = q[i].op; data1 = q[i].a; data2 = q[i].b; valid_in = 1'b1;
            for (int k = 1; k <= W + 2; k++) begin
                @(negedge clk);
                valid_in = 1'b0; alu_ctrl = 5'h00;
                checks++;
                if (busy !== (k <= W + 1)) begin errors++;
                    $display("FAIL md_busy op=%h cycle %0d got %b exp %b", q[i].op, k, busy, k <= W + 1); end
                checks++;
                if (md_done !== (k == W + 2)) begin errors++;
                    $display("FAIL md_done op=%h cycle %0d got %b exp %b", q[i].op, k, md_done, k == W + 2); end
            end
            checks++;
            if (hi !== q[i].h || lo !== q[i].l) begin errors++;
                $display("FAIL md_result op=%h a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h",
                         q[i].op, q[i].a, q[i].b, hi, lo, q[i].h, q[i].l); end
            hi_m = q[i].h; lo_m = q[i].l;
        end
    endtask

    task automatic test_stall();
        logic [63:0] m;
        logic stall_exp;
        m = ref_md(5'h10, 32'd1234567, 32'hFFFFFF89);
        @(negedge clk);
        alu_ctrl = 5'h10; data1 = 32'd1234567; data2 = 32'hFFFFFF89; valid_in = 1'b1;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            valid_in = 1'b1;
            alu_ctrl = (k == 5) ? 5'h01 : 5'h15;
            #1;
            stall_exp = (k <= W + 1) && (k != 5);
            checks++;
            if (stall !== stall_exp) begin errors++;
                $display("FAIL stall cycle %0d got %b exp %b", k, stall, stall_exp); end
            if (k == 5) begin
                checks++;
                if (alu_res !== data1 + data2) begin errors++;
                    $display("FAIL add_during_busy got %h exp %h", alu_res, data1 + data2); end
            end
        end
        checks++;
        if (alu_res !== m[31:0]) begin errors++;
            $display("FAIL mflo_after_stall got %h exp %h", alu_res, m[31:0]); end
        hi_m = m[63:32]; lo_m = m[31:0];
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        valid_in = 1'b1; alu_ctrl = 5'h16; data1 = 32'hCAFEF00D;
        #1;
        checks++;
        if (alu_res !== 32'h0) begin errors++; $display("FAIL mthi_res got %h exp 0", alu_res); end
        @(negedge clk);
        alu_ctrl = 5'h14; data1 = 32'h0;
        #1;
        checks++;
        if (alu_res !== 32'hCAFEF00D) begin errors++; $display("FAIL mfhi_after_mthi got %h exp cafef00d", alu_res); end
        @(negedge clk);
        alu_ctrl = 5'h17; data1 = 32'h13579BDF;
        @(negedge clk);
        alu_ctrl = 5'h15;
        #1;
        checks++;
        if (alu_res !== 32'h13579BDF) begin errors++; $display("FAIL mflo_after_mtlo got %h exp 13579bdf", alu_res); end
        checks++;
        if (hi !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo_kept_hi got %h exp cafef00d", hi); end
        hi_m = 32'hCAFEF00D; lo_m = 32'h13579BDF;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic test_flush();
        int done_cnt;
        @(negedge clk);
        valid_in = 1'b1; alu_ctrl = 5'h10; flush = 1'b1; data1 = 32'd3; data2 = 32'd4;
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept busy got %b exp 0", busy); end
        @(negedge clk);
        valid_in = 1'b1; alu_ctrl = 5'h12; data1 = 32'd1000; data2 = 32'd3;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            valid_in = 1'b0;
            flush = (k == 10);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (md_done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL flush_no_done pulses %0d exp 0", done_cnt); end
        checks++;
        if (hi !== hi_m || lo !== lo_m) begin errors++;
            $display("FAIL flush_hilo got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, hi_m, lo_m); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        valid_in = 1'b1; alu_ctrl = 5'h17; data1 = 32'hA5A5A5A5;
        @(negedge clk);
        valid_in = 1'b1; alu_ctrl = 5'h12; data1 = 32'd999; data2 = 32'd10;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            valid_in = 1'b0;
            rst_n = (k == 10) ? 1'b0 : 1'b1;
        end
        checks++;
        if (busy !== 1'b0 || md_done !== 1'b0) begin errors++;
            $display("FAIL reset_mid_ctrl got busy=%b done=%b exp 0 0", busy, md_done); end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin errors++;
            $display("FAIL reset_mid_hilo got hi=%h lo=%h exp 0 0", hi, lo); end
        hi_m = 32'h0; lo_m = 32'h0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        valid_in = 1'b1; alu_ctrl = 5'h11; data1 = 32'hFFFFFFFF; data2 = 32'h2;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            valid_in = 1'b1; alu_ctrl = 5'h13; data1 = 32'd100; data2 = 32'd7;
            checks++;
            if (busy !== (k <= W + 1) || md_done !== (k == W + 2)) begin errors++;
                $display("FAIL b2b_first cycle %0d got busy=%b done=%b", k, busy, md_done); end
        end
        checks++;
        if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin errors++;
            $display("FAIL b2b_first_result got hi=%h lo=%h exp 1 fffffffe", hi, lo); end
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            valid_in = 1'b0; alu_ctrl = 5'h00;
            checks++;
            if (busy !== (k <= W + 1) || md_done !== (k == W + 2)) begin errors++;
                $display("FAIL b2b_second cycle %0d got busy=%b done=%b", k, busy, md_done); end
        end
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin errors++;
            $display("FAIL b2b_second_result got hi=%h lo=%h exp 2 e", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_stall();
        test_mthi_mtlo();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised execute-stage ALU for the 5-stage MIPS pipeline. It extends the single-cycle integer ALU with NOR, SRA and SLTU, signed ADD/SUB overflow, and an iterative multiply/divide unit with architectural HI/LO registers. Single-cycle ops return combinationally in the EX cycle. MULT/DIV run multi-cycle behind a busy/stall handshake that the hazard unit uses to hold dependent HI/LO instructions.

## Interface
- WIDTH, 32, datapath width; even, >= 8
- SHAMT_W, $clog2(WIDTH), shift-amount width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- data1  in  WIDTH  operand A (rs)
- data2  in  WIDTH  operand B (rt/imm)
- shamt  in  SHAMT_W  shift amount
- alu_ctrl  in  5  operation select
- valid_in  in  1  EX stage holds a live instruction this cycle
- flush  in  1  abort in-flight multiply/divide
- alu_res  out  WIDTH  combinational result
- zero  out  1  combinational, 1 when data1 == data2
- overflow  out  1  combinational signed overflow, ADD/SUB only, else 0
- stall  out  1  combinational, hold the EX instruction
- busy  out  1  registered, multiply/divide in progress
- md_done  out  1  registered one-cycle completion pulse
- hi, lo  out  WIDTH  registered HI/LO

## Operation
- Codes (hex):
  - 00 SLL, 0F SRL, 08 SRA (arithmetic): data1 shifted by shamt.
  - 01 ADD, 02 SUB, 04 AND, 05 OR, 06 XOR, 03 NOR.
  - 07 LUI: data2[WIDTH/2-1:0] << WIDTH/2.
  - 0A SLT (signed), 0B SLTU (unsigned): result 1 or 0.
  - 0E CMP: alu_res = 0.
  - 10 MULT, 11 MULTU, 12 DIV, 13 DIVU.
  - 14 MFHI, 15 MFLO: alu_res = hi or lo.
  - 16 MTHI, 17 MTLO.
  - Undefined codes: alu_res = 0, no state change.
- For multiply/divide, MTxx, MFxx and undefined codes, alu_res = 0 unless stated above.
- ADD/SUB wrap modulo 2^WIDTH. overflow = operand signs agree (for SUB: A and ~B) and the result sign differs.
- Accept: a multiply/divide is accepted at the edge where valid_in=1, flush=0, busy=0. MTHI/MTLO write hi or lo = data1 under the same condition.
- stall = valid_in & busy & alu_ctrl in 10..17. Non-HI/LO ops never stall, and busy does not block them.
- FSM IDLE -> RUN -> FIX -> IDLE:
  - IDLE: accept loads operand magnitudes (absolute values for signed ops), signs and the op; -> RUN, count = 0.
  - RUN: WIDTH iterations, one bit per cycle. Multiply is shift-add into a 2*WIDTH product. Divide is restoring, one quotient bit per cycle. -> FIX after count = WIDTH-1.
  - FIX: sign correction, then write {hi,lo}. MULT/MULTU: {hi,lo} = product. DIV/DIVU: lo = quotient, hi = remainder. -> IDLE.
- Signed divide rules:
  - Quotient is negated if the operand signs differ. Remainder takes the dividend's sign (truncating division).
  - MIN / -1: lo = MIN, hi = 0.
- Divide by zero, signed or unsigned: full latency, lo = all ones, hi = original data1.
- flush in RUN/FIX: -> IDLE next edge, hi/lo untouched, no md_done. A flush in the same cycle as a would-be accept blocks the accept.
- Reset: state IDLE, count 0, hi = lo = 0, busy = 0, md_done = 0. Reset mid-operation discards the operation.

## Timing
- Single-cycle ops: zero latency, combinational from inputs.
- Multiply/divide accepted at edge E0:
  - busy = 1 for cycles 1..WIDTH+1.
  - hi/lo written at edge E(WIDTH+1).
  - md_done = 1 and busy = 0 in cycle WIDTH+2.
  - Total WIDTH+2 cycles (34 at WIDTH=32).
- A back-to-back multiply/divide may be accepted in the md_done cycle.
- MFHI/MFLO held by stall read the new value in the md_done cycle.
- MTHI at edge E, MFHI in the following cycle returns the new value. No same-cycle bypass.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> alu_res 0x80000000, overflow=1. SRA 0x80000000 by 4 -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1; SLT same operands -> 0. CMP 5 vs 5 -> zero=1.
- MULT 0xFFFFFFFD × 7 -> busy cycles 1..33, md_done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF × 2 -> hi=1, lo=0xFFFFFFFE.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5/0 -> lo=0xFFFFFFFF, hi=5 after 34 cycles.
- Issue MULT, then present MFLO with valid_in every cycle -> stall=1 in cycles 1..33, 0 in cycle 34 with alu_res = product low word. An ADD presented during busy -> stall=0.
- Flush at cycle 10 of DIV -> busy=0 in cycle 11, hi/lo unchanged, no md_done. Repeat with rst_n=0 at cycle 10 -> all registers zero at the next edge.
